// File: rtl/multi_index_down_counter_pkg.sv
// Types shared by the multi-channel index down counter and its channel slices.
package multi_index_down_counter_pkg;

    typedef enum logic {
        MODE_ONE_SHOT = 1'b0,
        MODE_RELOAD   = 1'b1
    } count_mode_e;

endpackage

// File: rtl/index_down_counter_ch.sv
// One independent down-counter channel: holds count, reload value and done pulse.
module index_down_counter_ch
    import multi_index_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             init,
    input  logic [WIDTH-1:0] count_init,
    input  logic             enable,
    input  logic             mode_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_next;
    logic             wrap;
    count_mode_e      mode;

    assign mode = count_mode_e'(mode_reload);

    // A load of 0 becomes all-ones via modular subtraction, giving a 2^WIDTH span.
    always_comb begin
        count_next  = count;
        reload_next = reload;
        wrap        = 1'b0;
        if (init) begin
            count_next  = count_init - ONE;
            reload_next = count_init;
        end else if (enable) begin
            if (count > ONE) begin
                count_next = count - ONE;
            end else if (count == ONE || mode == MODE_RELOAD) begin
                wrap       = 1'b1;
                count_next = (mode == MODE_RELOAD) ? reload - ONE : '0;
            end
        end
    end

    assign zero = init ? (count_init == ONE) : (count <= ONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            count  <= count_next;
            reload <= reload_next;
            done   <= wrap;
        end
    end

endmodule

// File: rtl/sys_defs.svh
// Shared system-wide defines: default index width and the channel slice helper.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define INDEX_NUM_LOG 4
`define INDEX_SLICE(idx, w) (idx)*(w) +: (w)

`endif

// File: rtl/multi_index_down_counter.sv
// Bank of CHANNELS independent down counters with a combined all-zero flag.
`include "sys_defs.svh"

module multi_index_down_counter
    import multi_index_down_counter_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = `INDEX_NUM_LOG
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       init,
    input  logic [CHANNELS*WIDTH-1:0] count_init,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       mode_reload,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       zero,
    output logic [CHANNELS-1:0]       done,
    output logic                      all_zero
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        index_down_counter_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clock       (clock),
            .reset_n     (reset_n),
            .init        (init[i]),
            .count_init  (count_init[`INDEX_SLICE(i, WIDTH)]),
            .enable      (enable[i]),
            .mode_reload (mode_reload[i]),
            .count       (count[`INDEX_SLICE(i, WIDTH)]),
            .zero        (zero[i]),
            .done        (done[i])
        );
    end

    assign all_zero = &zero;

endmodule
